// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, clock enable and received-word handshake for uart_rx
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  ena;
   logic                  rx_signal;
   logic                  rx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  frame_error;
   logic                  overrun;
   logic                  busy;

   modport master (
      output ena, rx_signal, rx_ready,
      input  rx_data, rx_valid, frame_error, overrun, busy
   );

   modport slave (
      input  ena, rx_signal, rx_ready,
      output rx_data, rx_valid, frame_error, overrun, busy
   );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, valid/ready output and error pulses
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 115_200,
   parameter int CLK_FREQ   = 50_000_000
) (
   input  logic     clk,
   input  logic     reset,
   uart_rx_if.slave bus
);
   localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
   localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
   localparam int CW = $clog2(PULSE_WIDTH) + 1;
   localparam int BW = $clog2(DATA_WIDTH) + 1;
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CW-1:0] FULL_LOAD = CW'(PULSE_WIDTH - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_PULSE_WIDTH - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t                state_q;
   logic [1:0]            sync_q;
   logic [CW-1:0]         clk_cnt_q;
   logic [BW-1:0]         bit_cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  rx_valid_q;
   logic                  frame_error_q;
   logic                  overrun_q;
   logic                  rx_s;
   logic                  sample;

   assign rx_s   = sync_q[1];
   assign sample = (clk_cnt_q == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         sync_q        <= 2'b11;
         clk_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else if (bus.ena) begin
         sync_q        <= {sync_q[0], bus.rx_signal};
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
         if (rx_valid_q && bus.rx_ready) begin
            rx_valid_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  state_q   <= S_START;
                  bit_cnt_q <= '0;
                  clk_cnt_q <= HALF_LOAD;
               end
            end
            S_START: begin
               if (!sample) begin
                  clk_cnt_q <= clk_cnt_q - 1'b1;
               end else if (!rx_s) begin
                  state_q   <= S_DATA;
                  clk_cnt_q <= FULL_LOAD;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_DATA: begin
               if (!sample) begin
                  clk_cnt_q <= clk_cnt_q - 1'b1;
               end else begin
                  shift_q[bit_cnt_q[IW-1:0]] <= rx_s;
                  clk_cnt_q                  <= FULL_LOAD;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= S_STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            S_STOP: begin
               if (!sample) begin
                  clk_cnt_q <= clk_cnt_q - 1'b1;
               end else if (rx_s) begin
                  state_q <= S_IDLE;
                  // A word consumed this very cycle frees the slot for the new one.
                  if (!rx_valid_q || bus.rx_ready) begin
                     rx_data_q  <= shift_q;
                     rx_valid_q <= 1'b1;
                  end else begin
                     overrun_q <= 1'b1;
                  end
               end else begin
                  state_q       <= S_BREAK;
                  frame_error_q <= 1'b1;
               end
            end
            S_BREAK: begin
               if (rx_s) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.frame_error = frame_error_q & bus.ena;
   assign bus.overrun     = overrun_q & bus.ena;
   assign bus.busy        = (state_q != S_IDLE);
endmodule
